// File: rtl/rnd_frame_bank.sv
// Bank of NUM LFSR-derived parameter words, refilled on a tempo tick and
// committed to rnd_bus only on frame_start so downstream patterns never tear.
//
// state | meaning
// IDLE  | waiting for tick; rnd_bus holds last committed set
// FILL  | LFSR stepping every clock, capturing one slot every STRIDE steps
// PEND  | shadow bank complete, waiting for frame_start to commit
module rnd_frame_bank #(
  parameter int          NUM    = 10,
  parameter int          STRIDE = 13,
  parameter logic [12:0] SEED   = 13'h1ACE
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              tick,
  input  logic              frame_start,
  output logic [13*NUM-1:0] rnd_bus,
  output logic              updated,
  output logic              busy,
  output logic              overrun
);

  localparam logic [12:0] SEED_EFF = (SEED == 13'h0000) ? 13'h0001 : SEED;
  localparam int          CW       = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam int          IW       = (NUM > 1) ? $clog2(NUM) : 1;

  typedef enum logic [1:0] {IDLE, FILL, PEND} state_t;

  state_t      state, state_nx;
  logic [12:0] lfsr, lfsr_nx;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [12:0] shadow [NUM];
  logic        cap, last_cap, commit;

  // All-zero is the LFSR lock-up state; recover to 1 rather than stepping.
  always_comb begin
    if (lfsr == 13'h0000) lfsr_nx = 13'h0001;
    else                  lfsr_nx = {lfsr[11:0], lfsr[12] ^ lfsr[3] ^ lfsr[2] ^ lfsr[0]};
  end

  assign cap      = (state == FILL) && (cnt == CW'(STRIDE - 1));
  assign last_cap = cap && (idx == IW'(NUM - 1));
  assign commit   = (state == PEND) && frame_start;
  assign busy     = (state != IDLE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (tick)        state_nx = FILL;
      FILL:    if (last_cap)    state_nx = PEND;
      PEND:    if (frame_start) state_nx = IDLE;
      default:                  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      lfsr    <= SEED_EFF;
      cnt     <= '0;
      idx     <= '0;
      updated <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state   <= state_nx;
      updated <= commit;
      overrun <= tick && busy;
      if (state == IDLE && tick) begin
        cnt <= '0;
        idx <= '0;
      end
      if (state == FILL) begin
        lfsr <= lfsr_nx;
        if (cap) begin
          cnt <= '0;
          idx <= idx + 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM; k++) shadow[k] <= '0;
      rnd_bus <= '0;
    end else begin
      if (cap) shadow[idx] <= lfsr_nx;
      // Whole bank moves in one edge so a frame never sees a mixed set.
      if (commit)
        for (int k = 0; k < NUM; k++) rnd_bus[13*k +: 13] <= shadow[k];
    end
  end

endmodule

// File: tb/tb_rnd_frame_bank.sv
// Self-checking bench for rnd_frame_bank: three builds (defaults, STRIDE=1,
// SEED=0 full-period) checked against an arithmetic LFSR model.
module tb_rnd_frame_bank;

  logic         clk_in = 1'b0;
  logic         reset  = 1'b0;
  logic         tick = 1'b0, frame_start = 1'b0;
  logic         tick1 = 1'b0, frame_start1 = 1'b0;
  logic         tick0 = 1'b0, frame_start0 = 1'b0;
  logic [129:0] rnd_bus, rnd_bus1;
  logic [12:0]  rnd_bus0;
  logic         updated, busy, overrun;
  logic         updated1, busy1, overrun1;
  logic         updated0, busy0, overrun0;

  int checks = 0;
  int failures = 0;
  int t = 0;

  always #5 clk_in = ~clk_in;

  rnd_frame_bank dut (
    .clk_in(clk_in), .reset(reset), .tick(tick), .frame_start(frame_start),
    .rnd_bus(rnd_bus), .updated(updated), .busy(busy), .overrun(overrun));

  rnd_frame_bank #(.NUM(10), .STRIDE(1), .SEED(13'h1ACE)) dut1 (
    .clk_in(clk_in), .reset(reset), .tick(tick1), .frame_start(frame_start1),
    .rnd_bus(rnd_bus1), .updated(updated1), .busy(busy1), .overrun(overrun1));

  rnd_frame_bank #(.NUM(1), .STRIDE(8191), .SEED(13'h0000)) dut0 (
    .clk_in(clk_in), .reset(reset), .tick(tick0), .frame_start(frame_start0),
    .rnd_bus(rnd_bus0), .updated(updated0), .busy(busy0), .overrun(overrun0));

  // Polynomial x^13+x^4+x^3+x+1 as a tap mask; feedback is the parity of tapped bits.
  function automatic logic [12:0] mstep(input logic [12:0] q);
    int v, taps, par;
    if (q == 13'h0000) return 13'h0001;
    v = int'(q);
    taps = v & 'h100D;
    par = $countones(taps) % 2;
    return 13'(((v * 2) % 8192) + par);
  endfunction

  function automatic logic [129:0] build_set(input int num, input int stride,
                                             inout logic [12:0] m);
    logic [129:0] bus = '0;
    for (int k = 0; k < num; k++) begin
      for (int s = 0; s < stride; s++) m = mstep(m);
      bus[13*k +: 13] = m;
    end
    return bus;
  endfunction

  task automatic check(input string tag, input logic [129:0] obs, input logic [129:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
    t++;
  endtask

  task automatic go_to(input int target);
    while (t < target) step();
  endtask

  logic [12:0]  m_main, m_one;
  logic [129:0] exp_fresh, exp_set, prev_bus;
  int r, zeros, first_ret;

  initial begin
    // Reset state
    #12;
    check("rst_bus", rnd_bus, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_updated", updated, 1'b0);
    check("rst_lfsr", dut.lfsr, 13'h1ACE);
    check("rst_lfsr_seed0", dut0.lfsr, 13'h0001);
    @(posedge clk_in); #1;
    reset = 1'b1;

    // STRIDE=1 build: tick at cycle 5, frame_start at cycle 40
    t = 0;
    m_one = 13'h1ACE;
    exp_set = build_set(10, 1, m_one);
    go_to(4);
    tick1 = 1'b1; step(); tick1 = 1'b0;
    go_to(39);
    frame_start1 = 1'b1; step(); frame_start1 = 1'b0;
    check("s1_slot0", rnd_bus1[12:0], 13'h159D);
    check("s1_slot1", rnd_bus1[25:13], 13'h0B3A);
    check("s1_all", rnd_bus1, exp_set);
    check("s1_upd_hi", updated1, 1'b1);
    step();
    check("s1_upd_lo", updated1, 1'b0);

    // Defaults: early frame_start inside FILL must not commit
    m_main = 13'h1ACE;
    exp_fresh = build_set(10, 13, m_main);
    tick = 1'b1; step(); tick = 1'b0; t = 0;
    check("d_busy", busy, 1'b1);
    go_to(49);
    frame_start = 1'b1; step(); frame_start = 1'b0;
    check("d_early_bus", rnd_bus, '0);
    check("d_early_upd", updated, 1'b0);
    go_to(199);
    frame_start = 1'b1; step(); frame_start = 1'b0;
    check("d_commit", rnd_bus, exp_fresh);
    check("d_upd_hi", updated, 1'b1);
    step();
    check("d_upd_lo", updated, 1'b0);
    check("d_idle", busy, 1'b0);

    // Extra ticks while busy are dropped with an overrun pulse
    exp_set = build_set(10, 13, m_main);
    tick = 1'b1; step(); tick = 1'b0; t = 0;
    go_to(19);
    tick = 1'b1; step(); tick = 1'b0;
    check("ov_hi", overrun, 1'b1);
    step();
    check("ov_lo", overrun, 1'b0);
    r = $urandom_range(25, 110);
    go_to(r);
    tick = 1'b1; step(); tick = 1'b0;
    check("ov_rand", overrun, 1'b1);
    go_to(130 + $urandom_range(1, 15));
    check("pend_busy", busy, 1'b1);
    // tick and frame_start together in PEND: commit, tick dropped
    tick = 1'b1; frame_start = 1'b1; step(); tick = 1'b0; frame_start = 1'b0;
    check("ov_commit", rnd_bus, exp_set);
    check("ov_both_upd", updated, 1'b1);
    check("ov_both_ov", overrun, 1'b1);
    check("ov_both_idle", busy, 1'b0);
    // tick and frame_start together in IDLE: fill starts, no commit
    tick = 1'b1; frame_start = 1'b1; step(); tick = 1'b0; frame_start = 1'b0; t = 0;
    check("idle_both_busy", busy, 1'b1);
    check("idle_both_upd", updated, 1'b0);
    check("idle_both_hold", rnd_bus, exp_set);

    // Reset mid-FILL discards the partial set and restarts from SEED
    go_to(60);
    reset = 1'b0;
    #2;
    check("mid_rst_bus", rnd_bus, '0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_lfsr", dut.lfsr, 13'h1ACE);
    step();
    reset = 1'b1;
    m_main = 13'h1ACE;
    exp_set = build_set(10, 13, m_main);
    tick = 1'b1; step(); tick = 1'b0; t = 0;
    go_to(200);
    frame_start = 1'b1; step(); frame_start = 1'b0;
    check("rst_fresh_model", rnd_bus, exp_set);
    check("rst_fresh_first", rnd_bus, exp_fresh);

    // Randomised rounds: random gaps, early frame_starts, stray ticks
    for (int round = 0; round < 4; round++) begin
      prev_bus = rnd_bus;
      exp_set = build_set(10, 13, m_main);
      repeat ($urandom_range(0, 12)) step();
      tick = 1'b1; step(); tick = 1'b0; t = 0;
      go_to($urandom_range(1, 60));
      frame_start = 1'b1; step(); frame_start = 1'b0;
      check("rnd_no_tear", rnd_bus, prev_bus);
      go_to($urandom_range(62, 120));
      tick = 1'b1; step(); tick = 1'b0;
      check("rnd_overrun", overrun, 1'b1);
      go_to(130 + $urandom_range(0, 30));
      frame_start = 1'b1; step(); frame_start = 1'b0;
      check("rnd_commit", rnd_bus, exp_set);
      check("rnd_upd", updated, 1'b1);
    end

    // SEED=0 build: full period of 8191 with no zero state
    tick0 = 1'b1; step(); tick0 = 1'b0;
    zeros = 0;
    first_ret = 0;
    for (int k = 1; k <= 8191; k++) begin
      step();
      if (dut0.lfsr == 13'h0000) zeros++;
      if (dut0.lfsr == 13'h0001 && first_ret == 0) first_ret = k;
    end
    check("per_zero", 130'(zeros), 130'(0));
    check("per_len", 130'(first_ret), 130'(8191));
    frame_start0 = 1'b1; step(); frame_start0 = 1'b0;
    check("per_commit", rnd_bus0, 13'h0001);
    check("per_upd", updated0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
